// File: rtl/uart_rx_pkg.sv
// Shared definitions for the parametrised UART receiver: FSM state encoding
// and the helper used to size the bit-period and bit-index counters.
package uart_rx_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } state_t;

    // Smallest legal frame geometry the receiver is designed for.
    localparam int MIN_CLKS_PER_BIT = 3;
    localparam int MIN_DATA_BITS    = 5;
    localparam int MAX_DATA_BITS    = 9;

    // Counter width able to hold 0..n-1; never narrower than one bit.
    function automatic int count_width(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchroniser for the asynchronous rx line plus a registered copy
// of the synchronised value used to detect a 1->0 (start-bit) edge.
module uart_rx_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic rx,
    output logic rx_sync,
    output logic rx_fall
);

    logic meta_q;
    logic sync_q;
    logic prev_q;

    // Synchroniser chain and edge-history flop.
    // NOTE: reset to 1 (line idle level) so leaving reset never looks like a start edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= 1'b1;
            sync_q <= 1'b1;
            prev_q <= 1'b1;
        end else begin
            // NOTE: non-blocking assignments make each flop sample the previous stage's old value.
            meta_q <= rx;
            sync_q <= meta_q;
            prev_q <= sync_q;
        end
    end

    assign rx_sync = sync_q;
    assign rx_fall = prev_q & ~sync_q;

endmodule

// File: rtl/uart_rx_param.sv
// Parametrised UART receiver: oversamples rx, deframes start/data/[parity]/stop
// and hands words to the consumer over a valid/ready port with per-word
// frame/parity flags and a sticky overrun flag.
// Optional feature macro: UART_RX_PARITY_EN (one parity bit between data and stop).
module uart_rx_param
    import uart_rx_pkg::*;
#(
    parameter int DATA_BITS    = 8,
    parameter int CLKS_PER_BIT = 5,
    parameter int PARITY_ODD   = 0
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    input  logic                 rx_ready,
    output logic                 frame_err,
    output logic                 parity_err,
    output logic                 overrun,
    output logic                 busy
);

`ifdef UART_RX_PARITY_EN
    localparam logic PAR_EN = 1'b1;
`else
    localparam logic PAR_EN = 1'b0;
`endif

    localparam int CNT_W = count_width(CLKS_PER_BIT);
    localparam int IDX_W = count_width(DATA_BITS);

    // Start bit is checked near its middle; later bits one full period apart.
    localparam logic [CNT_W-1:0] CNT_MID  = CNT_W'((CLKS_PER_BIT - 1) / 2);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_BITS - 1);
    localparam logic             ODD      = (PARITY_ODD != 0);

    logic rx_s;
    logic rx_fall;

    uart_rx_sync u_sync (
        .clk     (clk),
        .rst_n   (rst_n),
        .rx      (rx),
        .rx_sync (rx_s),
        .rx_fall (rx_fall)
    );

    state_t               state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [IDX_W-1:0]     idx_q, idx_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic                 done_q, done_d;
    logic                 ferr_q, ferr_d;
    logic                 perr_q, perr_d;

    logic                 parity_err_q;
    logic                 handshake;

    // Frame FSM, counters and shift register: state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            shift_q <= '0;
            done_q  <= 1'b0;
            ferr_q  <= 1'b0;
            perr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            shift_q <= shift_d;
            done_q  <= done_d;
            ferr_q  <= ferr_d;
            perr_q  <= perr_d;
        end
    end

    // Frame FSM next-state logic: walks start/data/[parity]/stop and flags completion.
    always_comb begin
        // NOTE: every signal gets a default first, so no path through the case infers a latch.
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        shift_d = shift_q;
        done_d  = 1'b0;
        ferr_d  = ferr_q;
        perr_d  = perr_q;

        case (state_q)
            ST_IDLE: begin
                // Only a real 1->0 edge starts a frame; a line stuck low is ignored.
                if (rx_fall) begin
                    state_d = ST_START;
                    cnt_d   = '0;
                end
            end

            ST_START: begin
                if (cnt_q == CNT_MID) begin
                    if (rx_s) begin
                        state_d = ST_IDLE;   // glitch: line back high mid start bit
                    end else begin
                        state_d = ST_DATA;
                        cnt_d   = '0;
                        idx_d   = '0;
                        perr_d  = 1'b0;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            ST_DATA: begin
                if (cnt_q == CNT_LAST) begin
                    cnt_d   = '0;
                    shift_d = {rx_s, shift_q[DATA_BITS-1:1]};   // LSB arrives first
                    if (idx_q == IDX_LAST) begin
                        state_d = PAR_EN ? ST_PARITY : ST_STOP;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            ST_PARITY: begin
                if (cnt_q == CNT_LAST) begin
                    cnt_d   = '0;
                    perr_d  = rx_s != ((^shift_q) ^ ODD);
                    state_d = ST_STOP;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            ST_STOP: begin
                // Return to IDLE on the sample itself so a back-to-back start edge is seen.
                if (cnt_q == CNT_LAST) begin
                    cnt_d   = '0;
                    ferr_d  = ~rx_s;
                    done_d  = 1'b1;
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign handshake = rx_valid & rx_ready;

    // Output register: loads a completed word unless the previous one is still pending.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_data      <= '0;
            rx_valid     <= 1'b0;
            frame_err    <= 1'b0;
            parity_err_q <= 1'b0;
            overrun      <= 1'b0;
        end else if (done_q) begin
            if (!rx_valid || rx_ready) begin
                // Empty slot, or the old word leaves this cycle: take the new one.
                rx_data      <= shift_q;
                rx_valid     <= 1'b1;
                frame_err    <= ferr_q;
                parity_err_q <= perr_q;
            end else begin
                overrun <= 1'b1;        // keep the old word, drop the new one
            end
        end else if (handshake) begin
            rx_valid <= 1'b0;
            overrun  <= 1'b0;
        end
    end

    assign parity_err = PAR_EN ? parity_err_q : 1'b0;
    assign busy       = (state_q != ST_IDLE);

endmodule

// File: tb/tb_uart_rx_param.sv
// Self-checking bench for uart_rx_param: directed vector table, randomized
// frames against a frame-level reference model, and hand-written sequences
// for glitch reject, overrun and mid-frame reset.
module tb_uart_rx_param;

    localparam int DB  = 8;
    localparam int CPB = 5;
    localparam int ODD = 0;

`ifdef UART_RX_PARITY_EN
    localparam bit PAR_EN = 1'b1;
`else
    localparam bit PAR_EN = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          rx = 1'b1;
    logic          rx_ready = 1'b1;
    logic [DB-1:0] rx_data;
    logic          rx_valid;
    logic          frame_err;
    logic          parity_err;
    logic          overrun;
    logic          busy;

    uart_rx_param #(
        .DATA_BITS    (DB),
        .CLKS_PER_BIT (CPB),
        .PARITY_ODD   (ODD)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .rx         (rx),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .rx_ready   (rx_ready),
        .frame_err  (frame_err),
        .parity_err (parity_err),
        .overrun    (overrun),
        .busy       (busy)
    );

    always #10 clk = ~clk;

    typedef struct {
        logic [DB-1:0] data;
        logic          ferr;
        logic          perr;
    } word_t;

    typedef struct {
        logic [DB-1:0] data;      // driven data
        logic          stop_bit;  // driven stop bit
        logic          par_flip;  // drive the wrong parity bit
        logic [DB-1:0] exp_data;
        logic          exp_ferr;
        logic          exp_perr;  // expected only when parity is built in
    } vec_t;

    int    tests = 0;
    int    fails = 0;
    word_t got_q[$];
    word_t exp_q[$];
    int    valid_cycles = 0;
    bit    busy_seen = 1'b0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
        end
    endtask

    // Correct parity bit for a word, optionally inverted.
    function automatic logic par_of(input logic [DB-1:0] d, input logic flip);
        return (^d) ^ (ODD != 0) ^ flip;
    endfunction

    task automatic hold_bit(input logic v);
        rx = v;
        repeat (CPB) @(negedge clk);
    endtask

    task automatic send_frame(input logic [DB-1:0] d, input logic par_bit, input logic stop_bit);
        hold_bit(1'b0);
        for (int i = 0; i < DB; i++) hold_bit(d[i]);
        if (PAR_EN) hold_bit(par_bit);
        hold_bit(stop_bit);
        rx = 1'b1;
    endtask

    task automatic idle_bits(input int n);
        rx = 1'b1;
        repeat (n * CPB) @(negedge clk);
    endtask

    task automatic wait_words(input string name, input int n);
        int k = 0;
        while (got_q.size() < n && k < 400) begin
            @(negedge clk);
            k++;
        end
        check({name, " word count"}, got_q.size(), n);
    endtask

    task automatic expect_word(input string name, input logic [DB-1:0] d,
                               input logic fe, input logic pe);
        word_t w;
        if (got_q.size() == 0) begin
            check({name, " word present"}, 0, 1);
        end else begin
            w = got_q.pop_front();
            check({name, " data"}, w.data, d);
            check({name, " frame_err"}, w.ferr, fe);
            check({name, " parity_err"}, w.perr, PAR_EN ? pe : 1'b0);
        end
    endtask

    // Capture every handshaken word and basic activity away from the active edge.
    initial begin
        forever begin
            @(negedge clk);
            if (rx_valid && rx_ready) got_q.push_back('{rx_data, frame_err, parity_err});
            if (rx_valid) valid_cycles++;
            if (busy) busy_seen = 1'b1;
        end
    end

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t  vecs[7];
        int    nwords;
        logic  stop_b, flip_b, prev_stop;
        logic [DB-1:0] d;

        vecs[0] = '{8'h55, 1'b1, 1'b0, 8'h55, 1'b0, 1'b0};
        vecs[1] = '{8'hA3, 1'b0, 1'b0, 8'hA3, 1'b1, 1'b0};
        vecs[2] = '{8'h5A, 1'b1, 1'b0, 8'h5A, 1'b0, 1'b0};
        vecs[3] = '{8'h00, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0};
        vecs[4] = '{8'hFF, 1'b1, 1'b1, 8'hFF, 1'b0, 1'b1};
        vecs[5] = '{8'h80, 1'b1, 1'b0, 8'h80, 1'b0, 1'b0};
        vecs[6] = '{8'h01, 1'b0, 1'b1, 8'h01, 1'b1, 1'b1};

        // Reset state
        repeat (3) @(negedge clk);
        check("reset rx_valid", rx_valid, 0);
        check("reset rx_data", rx_data, 0);
        check("reset frame_err", frame_err, 0);
        check("reset parity_err", parity_err, 0);
        check("reset overrun", overrun, 0);
        check("reset busy", busy, 0);
        rst_n = 1'b1;
        idle_bits(2);

        // Directed vector table, ready held high
        valid_cycles = 0;
        for (int i = 0; i < 7; i++) begin
            send_frame(vecs[i].data, par_of(vecs[i].data, vecs[i].par_flip), vecs[i].stop_bit);
            wait_words($sformatf("vec%0d", i), 1);
            expect_word($sformatf("vec%0d", i), vecs[i].exp_data, vecs[i].exp_ferr, vecs[i].exp_perr);
            check($sformatf("vec%0d overrun", i), overrun, 0);
            idle_bits(2);
        end
        check("valid one cycle per word", valid_cycles, 7);
        check("busy idle after table", busy, 0);

        // Short low pulse: start bit rejected
        busy_seen = 1'b0;
        rx = 1'b0;
        repeat (2) @(negedge clk);
        rx = 1'b1;
        repeat (15) @(negedge clk);
        check("glitch busy seen", busy_seen, 1);
        check("glitch busy back to 0", busy, 0);
        check("glitch no word", got_q.size(), 0);
        check("glitch rx_valid", rx_valid, 0);

`ifdef UART_RX_PARITY_EN
        // Even parity on 0x07: parity bit 0 is wrong, 1 is right
        send_frame(8'h07, 1'b0, 1'b1);
        wait_words("par0", 1);
        expect_word("par0", 8'h07, 1'b0, 1'b1);
        idle_bits(2);
        send_frame(8'h07, 1'b1, 1'b1);
        wait_words("par1", 1);
        expect_word("par1", 8'h07, 1'b0, 1'b0);
        idle_bits(2);
`endif

        // Randomized frames against the frame-level model
        got_q.delete();
        exp_q.delete();
        nwords = 30;
        prev_stop = 1'b1;
        for (int i = 0; i < nwords; i++) begin
            d      = DB'($urandom);
            stop_b = ($urandom_range(0, 5) != 0);
            flip_b = PAR_EN ? 1'($urandom_range(0, 3) == 0) : 1'b0;
            // A low stop bit leaves the line low; a frame needs a fresh falling edge.
            if (!prev_stop) idle_bits(1);
            else if ($urandom_range(0, 1) == 1) idle_bits($urandom_range(0, 2));
            exp_q.push_back('{d, ~stop_b, flip_b});
            send_frame(d, par_of(d, flip_b), stop_b);
            prev_stop = stop_b;
        end
        idle_bits(1);
        wait_words("rand", nwords);
        for (int i = 0; i < nwords; i++) begin
            word_t e;
            e = exp_q.pop_front();
            expect_word($sformatf("rand%0d", i), e.data, e.ferr, e.perr);
        end
        idle_bits(2);

        // Overrun: two words with ready low
        @(posedge clk); #2 rx_ready = 1'b0;
        @(negedge clk);
        send_frame(8'h01, par_of(8'h01, 1'b0), 1'b1);
        send_frame(8'h02, par_of(8'h02, 1'b0), 1'b1);
        repeat (10) @(negedge clk);
        check("ovr rx_valid", rx_valid, 1);
        check("ovr rx_data kept", rx_data, 8'h01);
        check("ovr overrun set", overrun, 1);
        check("ovr nothing taken", got_q.size(), 0);
        @(posedge clk); #2 rx_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("ovr rx_valid after hs", rx_valid, 0);
        check("ovr overrun after hs", overrun, 0);
        wait_words("ovr", 1);
        expect_word("ovr", 8'h01, 1'b0, 1'b0);
        idle_bits(2);

        // Reset in data bit 4 with a word pending
        @(posedge clk); #2 rx_ready = 1'b0;
        @(negedge clk);
        send_frame(8'h3C, par_of(8'h3C, 1'b0), 1'b1);
        repeat (10) @(negedge clk);
        check("rst pre rx_valid", rx_valid, 1);
        check("rst pre rx_data", rx_data, 8'h3C);
        hold_bit(1'b0);
        for (int i = 0; i < 4; i++) hold_bit(1'b1);
        rx = 1'b0;
        repeat (2) @(negedge clk);
        check("rst pre busy", busy, 1);
        rst_n = 1'b0;
        rx = 1'b1;
        #1;
        check("rst rx_valid", rx_valid, 0);
        check("rst rx_data", rx_data, 0);
        check("rst frame_err", frame_err, 0);
        check("rst busy", busy, 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        rx_ready = 1'b1;
        repeat (20) @(negedge clk);
        check("rst no partial word", got_q.size(), 0);
        check("rst rx_valid idle", rx_valid, 0);
        send_frame(8'hC3, par_of(8'hC3, 1'b0), 1'b1);
        wait_words("post rst", 1);
        expect_word("post rst", 8'hC3, 1'b0, 1'b0);
        idle_bits(2);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
